// File: rtl/crossbar_pkg.sv
// Shared definitions for the response scatter crossbar: default sizes,
// requester-id width helper and the per-requester slot record.
package crossbar_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int N_DEF      = 6;
    localparam int M_DEF      = 4;

    // Width of a requester index; never narrower than one bit so a
    // single-requester build still has a legal rid port.
    function automatic int idWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One requester's response holding register.
    typedef struct packed {
        logic                  valid;
        logic [DATA_W_DEF-1:0] data;
    } slot_t;

endpackage

// File: rtl/crossbar_scatter_slot.sv
// One requester's single-entry response slot. A load always wins over a
// drain, which is what allows a full slot to be emptied and refilled on the
// same edge when its consumer is ready.
module crossbar_scatter_slot
    import crossbar_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    slot_t slot_d;
    slot_t slot_q;

    // Next slot contents: load, else drain on handshake, else hold.
    always_comb begin
        slot_d = slot_q;
        if (load_i) begin
            slot_d.valid = 1'b1;
            slot_d.data  = data_i;
        end else if (slot_q.valid && ready_i) begin
            slot_d.valid = 1'b0;
        end
    end

    // Slot register; reset throws away whatever response was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign valid_o = slot_q.valid;
    assign data_o  = slot_q.data;

endmodule

// File: rtl/crossbar_scatter.sv
// Scatters responses arriving on M crossbar lanes into N requester slots.
// Lanes aimed at the same requester are resolved lowest-index-first; lanes
// carrying an id that names no requester are swallowed and counted.
module crossbar_scatter
    import crossbar_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int N      = N_DEF,
    parameter  int M      = M_DEF,
    localparam int ID_W   = idWidth(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [M-1:0]      rvalid,
    input  logic [DATA_W-1:0] rdata [M],
    input  logic [ID_W-1:0]   rid   [M],
    output logic [M-1:0]      rready,
    output logic [N-1:0]      ovalid,
    output logic [DATA_W-1:0] odata [N],
    input  logic [N-1:0]      oready,
    output logic [7:0]        err_cnt
);

    // rid is compared one bit wider so N == 2**ID_W still works.
    localparam logic [ID_W:0] N_LIM = (ID_W + 1)'(N);
    localparam int            SUM_W = 9 + $clog2(M + 1);

    logic [N-1:0]      slotFree;
    logic [N-1:0]      claimed;
    logic [N-1:0]      loadVec;
    logic [DATA_W-1:0] loadData [N];
    logic [M-1:0]      badVec;
    logic [SUM_W-1:0]  errSum;
    logic [7:0]        errCnt_d;
    logic [7:0]        errCnt_q;

    // A slot can take a new response if empty or being drained this cycle.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            slotFree[i] = !ovalid[i] || oready[i];
        end
    end

    // Lane arbitration: the first lane to name a requester claims it, so
    // later lanes with the same id lose even if the slot turns out busy.
    always_comb begin
        rready  = '0;
        badVec  = '0;
        claimed = '0;
        loadVec = '0;
        for (int i = 0; i < N; i++) begin
            loadData[i] = '0;
        end
        for (int j = 0; j < M; j++) begin
            if (rvalid[j]) begin
                if ({1'b0, rid[j]} >= N_LIM) begin
                    rready[j] = 1'b1;
                    badVec[j] = 1'b1;
                end else if (!claimed[rid[j]]) begin
                    claimed[rid[j]] = 1'b1;
                    if (slotFree[rid[j]]) begin
                        rready[j]         = 1'b1;
                        loadVec[rid[j]]   = 1'b1;
                        loadData[rid[j]]  = rdata[j];
                    end
                end
            end
        end
    end

    // Saturating add of this cycle's dropped responses to the error count.
    always_comb begin
        errSum = SUM_W'(errCnt_q);
        for (int j = 0; j < M; j++) begin
            errSum = errSum + SUM_W'(badVec[j]);
        end
        errCnt_d = (errSum > SUM_W'(255)) ? 8'hFF : errSum[7:0];
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errCnt_q <= '0;
        end else begin
            errCnt_q <= errCnt_d;
        end
    end

    assign err_cnt = errCnt_q;

    for (genvar i = 0; i < N; i++) begin : g_slot
        crossbar_scatter_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (loadVec[i]),
            .data_i  (loadData[i]),
            .ready_i (oready[i]),
            .valid_o (ovalid[i]),
            .data_o  (odata[i])
        );
    end

endmodule

// File: tb/tb_crossbar_scatter.sv
// Directed bench for crossbar_scatter. Stimulus pushes the expected payload
// per requester into a queue; a monitor pops and compares on every drain.
module tb_crossbar_scatter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  rvalid;
    logic [15:0] rdata [4];
    logic [2:0]  rid   [4];
    logic [3:0]  rready;
    logic [5:0]  ovalid;
    logic [15:0] odata [6];
    logic [5:0]  oready;
    logic [7:0]  err_cnt;

    logic [15:0] expQ [6][$];
    int          checks;
    int          passes;

    crossbar_scatter #(
        .DATA_W (16),
        .N      (6),
        .M      (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rvalid  (rvalid),
        .rdata   (rdata),
        .rid     (rid),
        .rready  (rready),
        .ovalid  (ovalid),
        .odata   (odata),
        .oready  (oready),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end else begin
            passes++;
        end
    endtask

    // Drive all lanes at once; lane 0 is element [0] of the packed vectors.
    task automatic applyStimulus(input logic [3:0] v, input logic [3:0][2:0] ids,
                                 input logic [3:0][15:0] dat);
        rvalid = v;
        for (int j = 0; j < 4; j++) begin
            rid[j]   = ids[j];
            rdata[j] = dat[j];
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every drain handshake must match the oldest expected payload.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 6; i++) begin
                if (ovalid[i] && oready[i]) begin
                    if (expQ[i].size() == 0) begin
                        checks++;
                        $display("[TB] FAIL unexpected_ovalid[%0d]: got data %h, required no response",
                                 i, odata[i]);
                    end else begin
                        checkOutput($sformatf("odata[%0d]", i), 32'(odata[i]), 32'(expQ[i].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        checks = 0;
        passes = 0;
        rst_n  = 1'b0;
        oready = 6'b111111;
        applyStimulus(4'b0000, '0, '0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_ovalid", 32'(ovalid), 32'h0);
        checkOutput("reset_err_cnt", 32'(err_cnt), 32'h0);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("reset_odata[%0d]", i), 32'(odata[i]), 32'h0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single hit on the first edge after release
        applyStimulus(4'b0001, {3'd0, 3'd0, 3'd0, 3'd3}, {16'h0, 16'h0, 16'h0, 16'hA5A5});
        expQ[3].push_back(16'hA5A5);
        @(negedge clk);
        checkOutput("hit_rready", 32'(rready), 32'b0001);
        nextCycle();
        applyStimulus(4'b0000, '0, '0);
        @(negedge clk);
        checkOutput("hit_ovalid", 32'(ovalid), 32'b001000);
        nextCycle();
        @(negedge clk);
        checkOutput("hit_drained", 32'(ovalid), 32'h0);
        nextCycle();

        // Conflict: lanes 1 and 2 both to requester 5
        applyStimulus(4'b0110, {3'd0, 3'd5, 3'd5, 3'd0}, {16'h0, 16'h0022, 16'h0011, 16'h0});
        expQ[5].push_back(16'h0011);
        @(negedge clk);
        checkOutput("conflict_rready_t0", 32'(rready), 32'b0010);
        nextCycle();
        applyStimulus(4'b0100, {3'd0, 3'd5, 3'd0, 3'd0}, {16'h0, 16'h0022, 16'h0, 16'h0});
        expQ[5].push_back(16'h0022);
        @(negedge clk);
        checkOutput("conflict_rready_t1", 32'(rready), 32'b0100);
        nextCycle();
        applyStimulus(4'b0000, '0, '0);
        @(negedge clk);
        checkOutput("conflict_ovalid_t2", 32'(ovalid), 32'b100000);
        nextCycle();

        // Backpressure on requester 0
        oready[0] = 1'b0;
        applyStimulus(4'b0001, {3'd0, 3'd0, 3'd0, 3'd0}, {16'h0, 16'h0, 16'h0, 16'h1234});
        expQ[0].push_back(16'h1234);
        @(negedge clk);
        checkOutput("bp_fill_rready", 32'(rready), 32'b0001);
        nextCycle();
        applyStimulus(4'b0001, {3'd0, 3'd0, 3'd0, 3'd0}, {16'h0, 16'h0, 16'h0, 16'h5678});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_stall_rready[%0d]", k), 32'(rready), 32'b0000);
            checkOutput($sformatf("bp_stall_odata[%0d]", k), 32'(odata[0]), 32'h1234);
            nextCycle();
        end
        oready[0] = 1'b1;
        expQ[0].push_back(16'h5678);
        @(negedge clk);
        checkOutput("bp_release_rready", 32'(rready), 32'b0001);
        nextCycle();
        applyStimulus(4'b0000, '0, '0);
        @(negedge clk);
        checkOutput("bp_refill_ovalid", 32'(ovalid), 32'b000001);
        nextCycle();

        // Full fan-out, lane j to requester j
        applyStimulus(4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, {16'hC003, 16'hC002, 16'hC001, 16'hC000});
        for (int j = 0; j < 4; j++) begin
            expQ[j].push_back(16'hC000 + 16'(j));
        end
        @(negedge clk);
        checkOutput("fanout_rready", 32'(rready), 32'b1111);
        nextCycle();
        applyStimulus(4'b0000, '0, '0);
        @(negedge clk);
        checkOutput("fanout_ovalid", 32'(ovalid), 32'b001111);
        nextCycle();

        // Out-of-range ids for 70 cycles
        applyStimulus(4'b1111, {3'd7, 3'd7, 3'd7, 3'd7}, {16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD});
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bad_rready[%0d]", k), 32'(rready), 32'b1111);
            checkOutput($sformatf("bad_err_cnt[%0d]", k), 32'(err_cnt), (4 * k > 255) ? 32'd255 : 32'(4 * k));
            checkOutput($sformatf("bad_ovalid[%0d]", k), 32'(ovalid), 32'h0);
            nextCycle();
        end
        applyStimulus(4'b0000, '0, '0);
        @(negedge clk);
        checkOutput("bad_err_cnt_final", 32'(err_cnt), 32'd255);
        nextCycle();

        // Reset mid-operation with slots 2 and 4 held
        oready = 6'b101011;
        applyStimulus(4'b0011, {3'd0, 3'd0, 3'd4, 3'd2}, {16'h0, 16'h0, 16'h4444, 16'h2222});
        @(negedge clk);
        checkOutput("rst_fill_rready", 32'(rready), 32'b0011);
        nextCycle();
        applyStimulus(4'b0000, '0, '0);
        @(negedge clk);
        checkOutput("rst_pre_ovalid", 32'(ovalid), 32'b010100);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_ovalid", 32'(ovalid), 32'h0);
        checkOutput("rst_mid_err_cnt", 32'(err_cnt), 32'h0);
        checkOutput("rst_mid_odata2", 32'(odata[2]), 32'h0);
        checkOutput("rst_mid_odata4", 32'(odata[4]), 32'h0);
        nextCycle();
        rst_n  = 1'b1;
        oready = 6'b111111;
        @(negedge clk);
        checkOutput("rst_post_ovalid", 32'(ovalid), 32'h0);
        nextCycle();
        applyStimulus(4'b1000, {3'd1, 3'd0, 3'd0, 3'd0}, {16'hBEEF, 16'h0, 16'h0, 16'h0});
        expQ[1].push_back(16'hBEEF);
        @(negedge clk);
        checkOutput("post_rst_rready", 32'(rready), 32'b1000);
        nextCycle();
        applyStimulus(4'b0000, '0, '0);
        @(negedge clk);
        checkOutput("post_rst_ovalid", 32'(ovalid), 32'b000010);
        nextCycle();
        nextCycle();

        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("queue_empty[%0d]", i), 32'(expQ[i].size()), 32'h0);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/crossbar_scatter.md
CROSSBAR_SCATTER -- requirements
Module: crossbar_scatter

Interface
REQ-001 Parameter DATA_W, default 16, data width of every lane and every requester port.
REQ-002 Parameter N, default 6, number of requester ports.
REQ-003 Parameter M, default 4, number of response lanes from the crossbar side.
REQ-004 Localparam ID_W = $clog2(N), requester-id width.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 rvalid  input  [M-1:0]  lane j carries a response.
REQ-008 rdata  input  [DATA_W-1:0] x M (unpacked)  response payload per lane.
REQ-009 rid  input  [ID_W-1:0] x M (unpacked)  destination requester index per lane.
REQ-010 rready  output  [M-1:0]  lane j response accepted this cycle.
REQ-011 ovalid  output  [N-1:0]  requester i holds a valid response.
REQ-012 odata  output  [DATA_W-1:0] x N (unpacked)  response payload per requester.
REQ-013 oready  input  [N-1:0]  requester i consumes its response this cycle.
REQ-014 err_cnt  output  8  saturating count of responses dropped for out-of-range rid.

Function
REQ-015 Lane handshake: transfer on lane j when rvalid[j] && rready[j]; rdata/rid SHALL be held stable by the source while rvalid[j] && !rready[j].
REQ-016 Requester handshake: slot i drained when ovalid[i] && oready[i].
REQ-017 Each requester SHALL own one 1-entry slot (valid bit + DATA_W register).
REQ-018 Slot i "free" = !ovalid[i] || oready[i] (same-cycle drain and refill allowed; combinational oready->rready path is intended).
REQ-019 Conflict: among lanes with rvalid and equal in-range rid, the lowest lane index wins; losers SHALL see rready=0 that cycle.
REQ-020 rready[j] = rvalid[j] && rid[j] < N && lane j wins for rid[j] && slot rid[j] free.
REQ-021 Out-of-range rid (rid[j] >= N): rready[j]=1 whenever rvalid[j], payload discarded, no slot touched.
REQ-022 err_cnt SHALL add the number of out-of-range transfers in the cycle, saturating at 255, no wrap.
REQ-023 Latency: transfer accepted at edge t, ovalid/odata visible after edge t; exactly 1 cycle.
REQ-024 Throughput: one response per requester per cycle, up to min(M,N) per cycle total.
REQ-025 Slot update on edge: win && free -> valid=1, data=rdata; else drained -> valid=0; else hold.
REQ-026 odata[i] SHALL hold its last value while ovalid[i]=0 (not required to clear).
REQ-027 No response reordering per requester: responses to requester i leave in acceptance order.
REQ-028 rready SHALL be 0 for every lane whose rvalid is 0.

Reset
REQ-029 While rst_n=0: ovalid='0, odata all '0, err_cnt=0; rready derived purely combinationally.
REQ-030 Reset asserted mid-transfer SHALL discard all slot contents; no partial response emitted after release.
REQ-031 First transfer possible on the first rising edge with rst_n=1.

Structure
REQ-032 Package crossbar_pkg SHALL hold DATA_W/N/M defaults, ID_W function and the slot struct typedef {valid, data}; shared with crossbar.
REQ-033 One sub-module crossbar_scatter_slot (one requester's slot register and drain logic), instantiated N times via generate.
REQ-034 Lane arbitration and err_cnt logic SHALL live in the top module.

Verification
REQ-035 Single hit: lane0 rvalid, rid=3, rdata=16'hA5A5, oready[3]=1 -> rready[0]=1; next cycle ovalid[3]=1, odata[3]=16'hA5A5; all other ovalid=0.
REQ-036 Conflict: lanes 1 and 2 both rid=5 (data 16'h0011, 16'h0022) -> cycle t rready=4'b0010; cycle t+1 odata[5]=16'h0011, lane 2 accepted at t+1, odata[5]=16'h0022 at t+2.
REQ-037 Backpressure: oready[0]=0, slot 0 full, lane 0 rid=0 -> rready[0]=0 held 5 cycles; raise oready[0] -> same-cycle rready[0]=1, new data visible next cycle.
REQ-038 Bad id: N=6, lanes 0..3 rid=7 for 70 cycles -> rready=4'b1111 every cycle, err_cnt reaches 255 after 64 cycles and stays 255, no ovalid asserted.
REQ-039 Full fan-out: 4 lanes rid=0,1,2,3 distinct data, all oready=1 -> rready=4'b1111, all four slots valid next cycle with matching data.
REQ-040 Reset mid-operation: slots 2 and 4 valid, rst_n pulled low between edges -> ovalid='0 and err_cnt=0 immediately, no stale data after release.
